wb_port_arbiter: RTL and testbench

Write-back port arbiter sitting between the pipeline's write-back stage, the long-latency multiply/divide unit, and the register file's single write port. It merges both result streams into one registered register-file write per cycle. The pipeline has priority; mul/div results are buffered in a small FIFO with a starvation guard. A pending-destination mask drives the decode-stage RAW stall.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/wb_fifo.sv | 67 ++++++
 rtl/wb_port_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline constants and write-back types used by the register-file write path.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int WB_ENTRY_W = REG_ADDR_W + DATA_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // Destination register sits in the upper bits of a packed entry.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_FIFO
    } wb_grant_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        reg_onehot    = '0;
        reg_onehot[r] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for mul/div results; also exposes per-entry valid flags and
// destination registers so the parent can build the pending-register mask.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WB_ENTRY_W
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_push,
    input  logic [WIDTH-1:0]                 i_push_data,
    input  logic                             i_pop,
    output logic                             o_full,
    output logic                             o_empty,
    output logic [WIDTH-1:0]                 o_head,
    output logic [DEPTH-1:0]                 o_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] o_regs
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; validity comes only from the pointers and count.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    // An entry is live when its distance from the read pointer is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PTR_W-1:0] w_off;
        assign w_off       = PTR_W'(gi) - r_rd_ptr;
        assign o_valid[gi] = ({1'b0, w_off} < r_count);
        assign o_regs[gi]  = r_mem[gi][WIDTH-1 -: REG_ADDR_W];
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Merges pipeline and mul/div results onto the single register-file write port,
// with pipeline priority, a buffered mul/div path and a starvation stall.
module wb_port_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PipeValid,
    input  logic [REG_ADDR_W-1:0] PipeReg,
    input  logic [DATA_W-1:0]     PipeData,
    input  logic                  MdValid,
    output logic                  MdReady,
    input  logic [REG_ADDR_W-1:0] MdReg,
    input  logic [DATA_W-1:0]     MdData,
    output logic                  RegWre,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0]     WriteData,
    output logic [NUM_REGS-1:0]   PendMask,
    output logic                  StallReq
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    wb_entry_t                       w_head;
    wb_entry_t                       w_push_entry;
    logic                            w_full;
    logic                            w_empty;
    logic [DEPTH-1:0]                w_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] w_regs;
    logic                            w_md_push;
    logic                            w_pop;
    logic                            w_lost;
    logic                            w_starve_hit;
    logic [CNT_W-1:0]                w_starve_inc;
    logic [NUM_REGS-1:0]             w_pend;
    wb_grant_e                       w_grant;

    logic                  r_reg_wre;
    logic [REG_ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0]     r_write_data;
    logic                  r_stall;
    logic [CNT_W-1:0]      r_starve;

    // Writes to r0 complete the handshake but are never stored.
    assign MdReady      = !w_full;
    assign w_md_push    = MdValid && !w_full && (MdReg != ZERO_REG);
    assign w_push_entry = '{rd: MdReg, data: MdData};

    wb_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(WB_ENTRY_W)
    ) u_fifo (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_push     (w_md_push),
        .i_push_data(w_push_entry),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head),
        .o_valid    (w_valid),
        .o_regs     (w_regs)
    );

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        w_grant = GNT_NONE;
        if (r_stall && !w_empty) begin
            w_grant = GNT_FIFO;
        end else if (PipeValid && (PipeReg != ZERO_REG)) begin
            w_grant = GNT_PIPE;
        end else if (!w_empty) begin
            w_grant = GNT_FIFO;
        end
    end

    assign w_pop        = (w_grant == GNT_FIFO);
    assign w_lost       = (w_grant == GNT_PIPE) && !w_empty;
    assign w_starve_inc = r_starve + 1'b1;
    assign w_starve_hit = w_lost && (w_starve_inc == STARVE_LIMIT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_reg_wre    <= 1'b0;
            r_write_reg  <= ZERO_REG;
            r_write_data <= '0;
        end else begin
            case (w_grant)
                GNT_PIPE: begin
                    r_reg_wre    <= 1'b1;
                    r_write_reg  <= PipeReg;
                    r_write_data <= PipeData;
                end
                GNT_FIFO: begin
                    r_reg_wre    <= 1'b1;
                    r_write_reg  <= w_head.rd;
                    r_write_data <= w_head.data;
                end
                default: r_reg_wre <= 1'b0;
            endcase
        end
    end

    // Any cycle that is not a lost arbitration is either a pop or an empty FIFO.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_stall <= w_starve_hit;
            if (!w_lost || w_starve_hit) r_starve <= '0;
            else                         r_starve <= w_starve_inc;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) w_pend = w_pend | reg_onehot(w_regs[i]);
        end
    end

    assign PendMask  = w_pend;
    assign RegWre    = r_reg_wre;
    assign WriteReg  = r_write_reg;
    assign WriteData = r_write_data;
    assign StallReq  = r_stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench for wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PipeValid = 1'b0;
    logic [4:0]  PipeReg = '0;
    logic [31:0] PipeData = '0;
    logic        MdValid = 1'b0;
    logic        MdReady;
    logic [4:0]  MdReg = '0;
    logic [31:0] MdData = '0;
    logic        RegWre;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] PendMask;
    logic        StallReq;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK(CLK), .RST(RST),
        .PipeValid(PipeValid), .PipeReg(PipeReg), .PipeData(PipeData),
        .MdValid(MdValid), .MdReady(MdReady), .MdReg(MdReg), .MdData(MdData),
        .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
        .PendMask(PendMask), .StallReq(StallReq)
    );

    always #5 CLK = ~CLK;

    // Reference model: a queue of pending mul/div results plus the starvation rule.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        m_q[$];
    bit          m_stall;
    int          m_starve;
    bit          e_wre;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    bit          hold;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] m = '0;
        foreach (m_q[i]) m[m_q[i].r] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_stall  = 1'b0;
        m_starve = 0;
        e_wre    = 1'b0;
        e_wreg   = '0;
        e_wdata  = '0;
        hold     = 1'b0;
    endtask

    task automatic model_step(input bit pv, input logic [4:0] preg, input logic [31:0] pdata,
                              input bit mv, input logic [4:0] mreg, input logic [31:0] mdata);
        bit ready     = (m_q.size() < DEPTH);
        bit nonempty  = (m_q.size() > 0);
        bit pipe_wins = !(m_stall && nonempty) && pv && (preg != 0);
        bit popping   = nonempty && !pipe_wins;
        e_wre = pipe_wins || popping;
        if (pipe_wins) begin
            e_wreg  = preg;
            e_wdata = pdata;
        end else if (popping) begin
            e_wreg  = m_q[0].r;
            e_wdata = m_q[0].d;
        end
        if (nonempty && pipe_wins) begin
            m_starve++;
            m_stall = (m_starve >= STARVE_MAX);
            if (m_stall) m_starve = 0;
        end else begin
            m_starve = 0;
            m_stall  = 1'b0;
        end
        if (popping) void'(m_q.pop_front());
        if (mv && ready && (mreg != 0)) m_q.push_back('{r: mreg, d: mdata});
    endtask

    task automatic check_outputs();
        check("RegWre", RegWre, e_wre);
        if (e_wre) begin
            check("WriteReg", WriteReg, e_wreg);
            check("WriteData", WriteData, e_wdata);
        end
        check("PendMask", PendMask, model_pend());
        check("StallReq", StallReq, m_stall);
        check("MdReady", MdReady, (m_q.size() < DEPTH));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_RegWre"}, RegWre, 0);
        check({tag, "_WriteReg"}, WriteReg, 0);
        check({tag, "_WriteData"}, WriteData, 0);
        check({tag, "_MdReady"}, MdReady, 1);
        check({tag, "_PendMask"}, PendMask, 0);
        check({tag, "_StallReq"}, StallReq, 0);
    endtask

    // Drives one cycle of inputs (called at a falling edge), then checks at the next one.
    // A stalled pipeline re-presents the result it offered during the stall cycle.
    task automatic cycle(input bit pv, input logic [4:0] preg, input logic [31:0] pdata,
                         input bit mv, input logic [4:0] mreg, input logic [31:0] mdata);
        if (hold) begin
            pv    = PipeValid;
            preg  = PipeReg;
            pdata = PipeData;
        end
        hold      = m_stall;
        PipeValid = pv;
        PipeReg   = preg;
        PipeData  = pdata;
        MdValid   = mv;
        MdReg     = mreg;
        MdData    = mdata;
        assert (!(pv && (preg != 0) && PendMask[preg]))
            else $error("RAW hazard: pipeline writer to pending register r%0d", preg);
        model_step(pv, preg, pdata, mv, mreg, mdata);
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic random_cycles(input int n, input int pv_pct);
        for (int i = 0; i < n; i++) begin
            bit          pv    = ($urandom_range(0, 99) < pv_pct);
            logic [4:0]  preg  = 5'($urandom_range(0, 15));
            logic [31:0] pdata = $urandom;
            bit          mv    = 1'($urandom_range(0, 1));
            logic [4:0]  mreg  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 23));
            logic [31:0] mdata = $urandom;
            cycle(pv, preg, pdata, mv, mreg, mdata);
        end
    endtask

    initial begin
        model_reset();
        #1;
        check_reset("rst_init");
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check_reset("rst_release");

        // Pipeline only: one cycle of latency, r0 writes suppressed.
        cycle(1, 5'd5, 32'h1234, 0, 0, 0);
        check("pipe_wre", RegWre, 1);
        check("pipe_reg", WriteReg, 5);
        check("pipe_data", WriteData, 32'h1234);
        cycle(1, 5'd0, 32'h5555, 0, 0, 0);
        check("pipe_r0_wre", RegWre, 0);

        // Two mul/div results queued behind pipeline writes, then drained in order.
        cycle(1, 5'd3, 32'h33, 1, 5'd7, 32'hAAAA);
        cycle(1, 5'd4, 32'h44, 1, 5'd9, 32'hBBBB);
        check("md_pend", PendMask, 32'h280);
        cycle(0, 0, 0, 0, 0, 0);
        check("md_first_reg", WriteReg, 7);
        check("md_first_data", WriteData, 32'hAAAA);
        check("md_bit7_clear", PendMask, 32'h200);
        cycle(0, 0, 0, 0, 0, 0);
        check("md_second_reg", WriteReg, 9);
        check("md_second_data", WriteData, 32'hBBBB);
        check("md_pend_empty", PendMask, 0);
        idle(1);

        // Fill the FIFO while the pipeline owns the port.
        for (int i = 0; i < DEPTH; i++)
            cycle(1, 5'(1 + i), 32'h100 + i, 1, 5'(16 + i), 32'h200 + i);
        check("full_ready", MdReady, 0);
        check("full_pend", PendMask, 32'h000F_0000);
        cycle(1, 5'd5, 32'h105, 1, 5'd20, 32'h220);
        check("full_drop", PendMask[20], 0);
        idle(8);

        // Starvation: one queued entry against a continuously busy pipeline.
        cycle(0, 0, 0, 1, 5'd25, 32'hC0DE);
        for (int k = 1; k <= STARVE_MAX; k++) cycle(1, 5'(k), 32'h100 + k, 0, 0, 0);
        check("starve_stall", StallReq, 1);
        check("starve_last_pipe", WriteReg, STARVE_MAX);
        cycle(1, 5'd5, 32'h105, 0, 0, 0);
        check("starve_head_reg", WriteReg, 25);
        check("starve_head_data", WriteData, 32'hC0DE);
        check("starve_stall_drop", StallReq, 0);
        cycle(1, 5'd6, 32'h106, 0, 0, 0);
        check("starve_replay_reg", WriteReg, 5);
        check("starve_replay_data", WriteData, 32'h105);
        idle(2);

        // Register 0 mul/div result: accepted, then discarded.
        check("r0_ready", MdReady, 1);
        cycle(0, 0, 0, 1, 5'd0, 32'hDEAD);
        check("r0_pend", PendMask, 0);
        check("r0_wre", RegWre, 0);
        idle(1);
        check("r0_no_pop", RegWre, 0);

        // Random traffic at several pipeline loads.
        random_cycles(600, 20);
        random_cycles(600, 60);
        random_cycles(600, 95);

        // Asynchronous reset with entries in flight.
        for (int i = 0; i < 3; i++) cycle(1, 5'(1 + i), $urandom, 1, 5'(17 + i), $urandom);
        #3;
        RST       = 1'b1;
        PipeValid = 1'b0;
        MdValid   = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        check_reset("rst_mid_release");
        idle(2);
        random_cycles(300, 70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
